// File: rtl/cpu_defs.sv
// cpu_defs: shared encodings and helpers for the five-stage MIPS pipeline.
`default_nettype none

package cpu_defs;

  localparam int TNEW_W = 2;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC8 = 2'b10;

  localparam logic [2:0] ALUOP_ADD = 3'd0;
  localparam logic [2:0] ALUOP_SUB = 3'd1;
  localparam logic [2:0] ALUOP_OR  = 3'd2;
  localparam logic [2:0] ALUOP_AND = 3'd3;
  localparam logic [2:0] ALUOP_SLT = 3'd4;
  localparam logic [2:0] ALUOP_LUI = 3'd5;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [4:0]  RA_REG    = 5'd31;

  // Field order fixes the bit layout of the control flop group.
  typedef struct packed {
    logic [1:0]        regdst;
    logic              alusrc;
    logic [1:0]        memtoreg;
    logic              regwrite;
    logic              memwrite;
    logic [2:0]        aluop;
    logic [TNEW_W-1:0] tnew;
    logic              valid;
    logic [4:0]        a3;
  } ctrl_t;

  function automatic logic [4:0] resolve_a3(input logic [1:0] regdst,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
    logic [4:0] a3;
    case (regdst)
      REGDST_RT: a3 = rt;
      REGDST_RD: a3 = rd;
      REGDST_RA: a3 = RA_REG;
      default:   a3 = 5'd0;
    endcase
    return a3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_dff.sv
// pipe_dff: pipeline flop group with async reset, synchronous clear and hold.
`default_nettype none

module pipe_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (clr)   q <= '0;
    else if (!hold) q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with bubble/flush, hold and a saturating bubble counter.
`default_nettype none

module id_ex_reg
  import cpu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              hold,
  input  logic              valid_D,
  input  logic [31:0]       instr_D,
  input  logic [DATA_W-1:0] pc8_D,
  input  logic [DATA_W-1:0] rs_data_D,
  input  logic [DATA_W-1:0] rt_data_D,
  input  logic [DATA_W-1:0] ext_D,
  input  logic [1:0]        RegDst_D,
  input  logic              ALUSrc_D,
  input  logic [1:0]        MemtoReg_D,
  input  logic              RegWrite_D,
  input  logic              MemWrite_D,
  input  logic [2:0]        ALUOp_D,
  input  logic [TNEW_W-1:0] Tnew_D,
  output logic [31:0]       instr_E,
  output logic [DATA_W-1:0] pc8_E,
  output logic [DATA_W-1:0] rs_data_E,
  output logic [DATA_W-1:0] rt_data_E,
  output logic [DATA_W-1:0] ext_E,
  output logic [1:0]        RegDst_E,
  output logic              ALUSrc_E,
  output logic [1:0]        MemtoReg_E,
  output logic              RegWrite_E,
  output logic              MemWrite_E,
  output logic [2:0]        ALUOp_E,
  output logic [TNEW_W-1:0] Tnew_E,
  output logic [4:0]        A3_E,
  output logic              valid_E,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int DATA_GRP_W = 32 + 3 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // An invalid instruction arriving on a normal load is squashed exactly like clr;
  // hold still takes precedence over that load.
  logic bubble_ld;
  logic pc_hold;
  logic [4:0] a3_D;
  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic [DATA_GRP_W-1:0] data_d;
  logic [DATA_GRP_W-1:0] data_q;
  logic [CNT_W-1:0] cnt_r;

  assign bubble_ld = clr | (~hold & ~valid_D);
  assign pc_hold   = hold & ~clr;
  assign a3_D      = (valid_D && RegWrite_D)
                     ? resolve_a3(RegDst_D, instr_D[20:16], instr_D[15:11]) : 5'd0;

  assign ctrl_d = '{regdst: RegDst_D, alusrc: ALUSrc_D, memtoreg: MemtoReg_D,
                    regwrite: RegWrite_D, memwrite: MemWrite_D, aluop: ALUOp_D,
                    tnew: Tnew_D, valid: valid_D, a3: a3_D};
  assign data_d = {instr_D, rs_data_D, rt_data_D, ext_D};

  pipe_dff #(.W($bits(ctrl_t))) u_ctrl (
    .clk(clk), .reset(reset), .clr(bubble_ld), .hold(hold), .d(ctrl_d), .q(ctrl_q)
  );

  pipe_dff #(.W(DATA_GRP_W)) u_data (
    .clk(clk), .reset(reset), .clr(bubble_ld), .hold(hold), .d(data_d), .q(data_q)
  );

  // PC+8 is never cleared by a bubble so the EX stage keeps a meaningful PC.
  pipe_dff #(.W(DATA_W)) u_addr (
    .clk(clk), .reset(reset), .clr(1'b0), .hold(pc_hold), .d(pc8_D), .q(pc8_E)
  );

  assign RegDst_E   = ctrl_q.regdst;
  assign ALUSrc_E   = ctrl_q.alusrc;
  assign MemtoReg_E = ctrl_q.memtoreg;
  assign RegWrite_E = ctrl_q.regwrite;
  assign MemWrite_E = ctrl_q.memwrite;
  assign ALUOp_E    = ctrl_q.aluop;
  assign Tnew_E     = ctrl_q.tnew;
  assign valid_E    = ctrl_q.valid;
  assign A3_E       = ctrl_q.a3;

  assign {instr_E, rs_data_E, rt_data_E, ext_E} = data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         cnt_r <= '0;
    else if (clr && cnt_r != CNT_MAX)  cnt_r <= cnt_r + CNT_ONE;
  end

  assign bubble_cnt = cnt_r;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: table-driven checks of id_ex_reg plus bubble, hold, priority and saturation sequences.
`default_nettype none

module tb_id_ex_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] ext;
    logic [1:0]  regdst;
    logic        alusrc;
    logic [1:0]  memtoreg;
    logic        regwrite;
    logic        memwrite;
    logic [2:0]  aluop;
    logic [1:0]  tnew;
    logic        valid;
  } stage_t;

  typedef struct {
    logic   clr;
    stage_t d;
    logic   [4:0] a3;
  } vec_t;

  logic clk = 1'b0;
  logic reset, clr, hold;
  stage_t din;

  logic [31:0] instr_E, pc8_E, rs_data_E, rt_data_E, ext_E;
  logic [1:0] RegDst_E, MemtoReg_E, Tnew_E;
  logic ALUSrc_E, RegWrite_E, MemWrite_E, valid_E;
  logic [2:0] ALUOp_E;
  logic [4:0] A3_E;
  logic [15:0] bubble_cnt;

  logic [31:0] s_instr_E, s_pc8_E, s_rs_data_E, s_rt_data_E, s_ext_E;
  logic [1:0] s_RegDst_E, s_MemtoReg_E, s_Tnew_E;
  logic s_ALUSrc_E, s_RegWrite_E, s_MemWrite_E, s_valid_E;
  logic [2:0] s_ALUOp_E;
  logic [4:0] s_A3_E;
  logic [3:0] s_bubble_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .clr(clr), .hold(hold), .valid_D(din.valid),
    .instr_D(din.instr), .pc8_D(din.pc8), .rs_data_D(din.rs), .rt_data_D(din.rt),
    .ext_D(din.ext), .RegDst_D(din.regdst), .ALUSrc_D(din.alusrc),
    .MemtoReg_D(din.memtoreg), .RegWrite_D(din.regwrite), .MemWrite_D(din.memwrite),
    .ALUOp_D(din.aluop), .Tnew_D(din.tnew),
    .instr_E(instr_E), .pc8_E(pc8_E), .rs_data_E(rs_data_E), .rt_data_E(rt_data_E),
    .ext_E(ext_E), .RegDst_E(RegDst_E), .ALUSrc_E(ALUSrc_E), .MemtoReg_E(MemtoReg_E),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .ALUOp_E(ALUOp_E),
    .Tnew_E(Tnew_E), .A3_E(A3_E), .valid_E(valid_E), .bubble_cnt(bubble_cnt)
  );

  id_ex_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .clr(clr), .hold(hold), .valid_D(din.valid),
    .instr_D(din.instr), .pc8_D(din.pc8), .rs_data_D(din.rs), .rt_data_D(din.rt),
    .ext_D(din.ext), .RegDst_D(din.regdst), .ALUSrc_D(din.alusrc),
    .MemtoReg_D(din.memtoreg), .RegWrite_D(din.regwrite), .MemWrite_D(din.memwrite),
    .ALUOp_D(din.aluop), .Tnew_D(din.tnew),
    .instr_E(s_instr_E), .pc8_E(s_pc8_E), .rs_data_E(s_rs_data_E), .rt_data_E(s_rt_data_E),
    .ext_E(s_ext_E), .RegDst_E(s_RegDst_E), .ALUSrc_E(s_ALUSrc_E), .MemtoReg_E(s_MemtoReg_E),
    .RegWrite_E(s_RegWrite_E), .MemWrite_E(s_MemWrite_E), .ALUOp_E(s_ALUOp_E),
    .Tnew_E(s_Tnew_E), .A3_E(s_A3_E), .valid_E(s_valid_E), .bubble_cnt(s_bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic stage_t bubble_of(input stage_t d);
    stage_t b = '0;
    b.pc8 = d.pc8;
    return b;
  endfunction

  task automatic check_stage(input string tag, input stage_t e, input logic [4:0] ea3,
                             input logic [15:0] ecnt);
    chk({tag, ".instr"},    64'(instr_E),    64'(e.instr));
    chk({tag, ".pc8"},      64'(pc8_E),      64'(e.pc8));
    chk({tag, ".rs"},       64'(rs_data_E),  64'(e.rs));
    chk({tag, ".rt"},       64'(rt_data_E),  64'(e.rt));
    chk({tag, ".ext"},      64'(ext_E),      64'(e.ext));
    chk({tag, ".RegDst"},   64'(RegDst_E),   64'(e.regdst));
    chk({tag, ".ALUSrc"},   64'(ALUSrc_E),   64'(e.alusrc));
    chk({tag, ".MemtoReg"}, 64'(MemtoReg_E), 64'(e.memtoreg));
    chk({tag, ".RegWrite"}, 64'(RegWrite_E), 64'(e.regwrite));
    chk({tag, ".MemWrite"}, 64'(MemWrite_E), 64'(e.memwrite));
    chk({tag, ".ALUOp"},    64'(ALUOp_E),    64'(e.aluop));
    chk({tag, ".Tnew"},     64'(Tnew_E),     64'(e.tnew));
    chk({tag, ".valid"},    64'(valid_E),    64'(e.valid));
    chk({tag, ".A3"},       64'(A3_E),       64'(ea3));
    chk({tag, ".cnt"},      64'(bubble_cnt), 64'(ecnt));
  endtask

  //           instr         pc8           rs            rt            ext           rd  as mr  rw mw op    tn v
  localparam stage_t ADDU = {32'h00851021, 32'h0000_1008, 32'h1111_0001, 32'h2222_0002, 32'h0000_1021, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0, 2'd1, 1'b1};
  localparam stage_t JAL  = {32'h0C000010, 32'h0000_2008, 32'h3333_0003, 32'h4444_0004, 32'h0000_0010, 2'b10, 1'b0, 2'b10, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1};
  localparam stage_t LW   = {32'h8C880004, 32'h0000_300C, 32'h5555_0005, 32'h6666_0006, 32'h0000_0004, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 3'd0, 2'd2, 1'b1};
  localparam stage_t ORI  = {32'h34830007, 32'h0000_4010, 32'h7777_0007, 32'h8888_0008, 32'h0000_0007, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3'd2, 2'd1, 1'b1};
  localparam stage_t SW   = {32'hAC850008, 32'h0000_5014, 32'h9999_0009, 32'hAAAA_000A, 32'h0000_0008, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 3'd0, 2'd0, 1'b1};

  vec_t vecs[8];
  stage_t v, e;
  logic [15:0] exp_cnt;

  initial begin
    stage_t jal_nw, rd11, lw_inv;
    jal_nw = JAL;  jal_nw.regwrite = 1'b0;
    rd11   = ADDU; rd11.regdst = 2'b11;
    lw_inv = LW;   lw_inv.valid = 1'b0;
    vecs[0] = '{clr: 1'b0, d: ADDU,   a3: 5'd2};
    vecs[1] = '{clr: 1'b0, d: JAL,    a3: 5'd31};
    vecs[2] = '{clr: 1'b0, d: jal_nw, a3: 5'd0};
    vecs[3] = '{clr: 1'b0, d: LW,     a3: 5'd8};
    vecs[4] = '{clr: 1'b0, d: rd11,   a3: 5'd0};
    vecs[5] = '{clr: 1'b0, d: lw_inv, a3: 5'd0};
    vecs[6] = '{clr: 1'b1, d: ADDU,   a3: 5'd0};
    vecs[7] = '{clr: 1'b0, d: ORI,    a3: 5'd3};

    // Async reset lands between edges on a loaded register.
    reset = 1'b1; clr = 1'b0; hold = 1'b0; din = ADDU;
    tick(); tick();
    reset = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1 check_stage("reset_async", '0, 5'd0, 16'd0);
    tick();
    reset = 1'b0;
    check_stage("reset_held", '0, 5'd0, 16'd0);

    exp_cnt = 16'd0;
    for (int i = 0; i < 8; i++) begin
      clr = vecs[i].clr;
      din = vecs[i].d;
      tick();
      if (vecs[i].clr) exp_cnt++;
      e = (vecs[i].clr || !vecs[i].d.valid) ? bubble_of(vecs[i].d) : vecs[i].d;
      check_stage($sformatf("vec%0d", i), e, vecs[i].a3, exp_cnt);
    end

    // Three consecutive bubbles with a valid sw in ID.
    clr = 1'b0; hold = 1'b0;
    #2 reset = 1'b1; #2 reset = 1'b0;
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = SW; v.pc8 = SW.pc8 + 32'(4 * i);
      din = v;
      tick();
      chk($sformatf("bub%0d.MemWrite", i), 64'(MemWrite_E), 64'd0);
      chk($sformatf("bub%0d.valid", i),    64'(valid_E),    64'd0);
      chk($sformatf("bub%0d.instr", i),    64'(instr_E),    64'd0);
      chk($sformatf("bub%0d.pc8", i),      64'(pc8_E),      64'(v.pc8));
    end
    chk("bub.cnt", 64'(bubble_cnt), 64'd3);

    // clr and hold together: bubble wins and counts.
    clr = 1'b0; din = ADDU;
    tick();
    check_stage("load_before_pri", ADDU, 5'd2, 16'd3);
    clr = 1'b1; hold = 1'b1; din = LW;
    tick();
    check_stage("clr_hold", bubble_of(LW), 5'd0, 16'd4);

    // Hold alone freezes everything, including over an invalid ID slot.
    clr = 1'b0; hold = 1'b0; din = ADDU;
    tick();
    hold = 1'b1; din = LW;
    tick();
    check_stage("hold1", ADDU, 5'd2, 16'd4);
    din = JAL;
    tick();
    check_stage("hold2", ADDU, 5'd2, 16'd4);
    din = lw_inv;
    tick();
    check_stage("hold_inv", ADDU, 5'd2, 16'd4);

    // Saturation on the 4-bit instance.
    hold = 1'b0;
    #2 reset = 1'b1; #2 reset = 1'b0;
    clr = 1'b1; din = SW;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat.pre", 64'(s_bubble_cnt), 64'd14);
    end
    chk("sat.cnt4",  64'(s_bubble_cnt), 64'd15);
    chk("sat.cnt16", 64'(bubble_cnt),   64'd20);
    clr = 1'b0;
    tick();
    chk("sat.stay", 64'(s_bubble_cnt), 64'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the five-stage MIPS core. It sits directly downstream of the Control decoder and the register file.
- Captures the decoded control bundle, operands, write-back address and hazard timing (Tnew) each cycle.
- Supports bubble insertion (load-use stall), flush and hold.
- Keeps a saturating count of bubbles inserted, for performance debug.

## Interface
- `DATA_W`, 32, datapath width (operands, PC+8, extended immediate)
- `CNT_W`, 16, bubble counter width
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high
- `clr` in 1: load a bubble this edge (load-use stall from hazard unit)
- `hold` in 1: keep current contents (downstream freeze)
- `valid_D` in 1: ID holds a real instruction
- `instr_D` in 32: instruction word
- `pc8_D` in DATA_W: PC+8 of the instruction
- `rs_data_D`, `rt_data_D` in DATA_W: register-file read data, already forwarded
- `ext_D` in DATA_W: extended immediate
- `RegDst_D` in 2: 00 rt, 01 rd, 10 $31
- `ALUSrc_D` in 1
- `MemtoReg_D` in 2
- `RegWrite_D` in 1
- `MemWrite_D` in 1
- `ALUOp_D` in 3
- `Tnew_D` in 2: cycles from E until the result is available (0..2)
- `*_E` out, same widths: registered copies of all `_D` inputs above
- `A3_E` out 5: write-back register number
- `valid_E` out 1
- `bubble_cnt` out CNT_W: bubbles inserted since reset, saturating

## Operation
- Priority at each rising edge: `reset` (async), then `clr`, then `hold`, then load.
- **Load:**
  - Every `_E` output takes its `_D` value.
  - `A3_E` is resolved from `RegDst_D`: 00 gives instr[20:16], 01 gives instr[15:11], 10 gives 5'd31, 11 gives 0.
  - If `RegWrite_D`=0 or `valid_D`=0, `A3_E`=0, so the hazard unit never matches a non-writer.
  - If `valid_D`=0, all enables are forced low, exactly as for a bubble.
- **Bubble** (`clr`=1, or load with `valid_D`=0):
  - All outputs go to their reset values, except `pc8_E`, which loads `pc8_D` (keeps exception/debug PC continuity).
- **Hold:** all registers keep their value, and `bubble_cnt` does not change.
- **`bubble_cnt`:**
  - Increments on every edge where `clr`=1.
  - Saturates at 2^CNT_W−1.
  - `hold` with `clr` low never increments it.
- **`Tnew_E`:** loaded unchanged. The downstream EX/MEM register decrements it with a floor at 0, so no arithmetic is done here.
- Contains no combinational path from any input to any output.

## Timing
- Latency: 1 cycle from `_D` inputs to `_E` outputs.
- Reset values, for all outputs: `instr_E`=0 (nop), `pc8_E`=0, data=0, all control=0, `A3_E`=0, `Tnew_E`=0, `valid_E`=0, `bubble_cnt`=0.
- `reset` asserted mid-cycle clears the outputs immediately (asynchronous). Release is synchronous to the design through the next edge.
- `clr` and `hold` both high: the bubble wins and the counter increments.
- `clr` held for N cycles: N bubbles and N increments.
- Consecutive bubbles are legal.

## Structure
- Shared package `cpu_defs`, holding:
  - RegDst encodings `REGDST_RT/RD/RA`
  - MemtoReg encodings
  - ALUOp codes
  - `NOP_INSTR`=32'h0
  - `RA_REG`=5'd31
  - Tnew width
- Natural sub-module: `pipe_dff`, a parameterized-width flop with async reset, `clr` (load reset value) and `hold`. It is instantiated per field group: control, data, addr.
- The `A3` mux and the bubble counter live in the top level.

## Test plan
- **Reset:** drive every `_D` input non-zero and assert `reset` between edges → all outputs 0 immediately; `bubble_cnt`=0.
- **Load addu:** `instr_D`=32'h00851021, `RegDst_D`=01, `RegWrite_D`=1, `Tnew_D`=1, `valid_D`=1 → next edge: `A3_E`=2, `Tnew_E`=1, `valid_E`=1, `instr_E`=32'h00851021.
- **jal-style write:** `RegDst_D`=10, `RegWrite_D`=1 → `A3_E`=31. Same stimulus with `RegWrite_D`=0 → `A3_E`=0.
- **Bubble:** `clr`=1 for 3 edges with a valid sw in ID →
  - `MemWrite_E`=0, `valid_E`=0, `instr_E`=0 on each of those edges
  - `pc8_E` tracks `pc8_D`
  - `bubble_cnt`=3
- **Priority:** `clr`=`hold`=1 → bubble loaded and counter increments. `hold`=1 alone for 2 edges → outputs and counter unchanged despite changing `_D` inputs.
- **Saturation:** CNT_W=4, `clr` held for 20 edges → `bubble_cnt` stops at 15.
